mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_BITS, default 8: byte-address width of internal storage, giving 2^ADDR_BITS bytes.
REQ-002 Parameter WAIT_CYCLES, default 1, range 0..15: wait states inserted before each response.
REQ-003 Port clk, input, 1: single clock; all state changes on rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-low reset.
REQ-005 Port req, input, 1: initiator request, level; held until ack is seen.
REQ-006 Port wr, input, 1: 1 = write, 0 = read; qualified by req.
REQ-007 Port address, input, 32: byte address; bits above ADDR_BITS-1 are ignored (aliased).
REQ-008 Port datain, input, 32: write data.
REQ-009 Port dataout, output, 32: read data; registered.
REQ-010 Port ack, output, 1: one-cycle completion pulse.
REQ-011 Port err, output, 1: one-cycle error pulse, coincident with ack; see Configuration.
REQ-012 Port busy, output, 1: high in states WAIT and RESP.

Function
REQ-013 The FSM SHALL have states IDLE, WAIT and RESP.
REQ-014 In IDLE with req=1, the block SHALL latch address[ADDR_BITS-1:0], wr and datain, and load a counter with WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES>0, else RESP.
REQ-015 In WAIT, the counter SHALL decrement each cycle; on reaching 0 the FSM SHALL enter RESP.
  - req, wr, address and datain are ignored while in WAIT.
REQ-016 On the edge entering RESP, the access SHALL take effect and ack SHALL be high for exactly the RESP cycle.
  - ack first rises WAIT_CYCLES+1 cycles after the edge that sampled req.
REQ-017 Read: dataout SHALL be {m[a], m[a+1], m[a+2], m[a+3]} (big-endian), updated on the edge entering RESP.
REQ-018 Write: m[a]..m[a+3] SHALL take datain[31:24]..datain[7:0] on the edge entering RESP.
  - dataout is unchanged by a write.
REQ-019 Byte indices a+1..a+3 SHALL wrap modulo 2^ADDR_BITS; e.g. a=0xFF with ADDR_BITS=8 touches 0xFF, 0x00, 0x01, 0x02.
REQ-020 dataout SHALL hold its value between reads.
REQ-021 RESP SHALL always return to IDLE.
  - If req is still high in IDLE, a new transaction starts; the initiator drops req on the edge at which ack is seen.
REQ-022 No request SHALL be accepted outside IDLE.
  - Throughput is at most one transaction per WAIT_CYCLES+2 cycles.

Reset
REQ-023 While reset=0, the block SHALL hold: state IDLE, dataout=0, ack=0, err=0, busy=0, counter=0.
REQ-024 Storage contents SHALL NOT be cleared by reset.
REQ-025 Reset asserted in WAIT SHALL abort the transaction; a pending write is never committed.
REQ-026 The first request SHALL be sampled on the first rising edge after reset deasserts.

Configuration
REQ-027 Macro MEM_RESPONDER_ALIGN_CHECK_EN: when defined, a request with address[1:0]!=0 SHALL still complete normally in timing.
  - err is pulsed together with ack.
  - A write is suppressed and dataout is unchanged.
REQ-028 When MEM_RESPONDER_ALIGN_CHECK_EN is undefined, err SHALL be tied to 0 and unaligned accesses SHALL proceed per REQ-017 to REQ-019.

Verification
REQ-029 Default parameters, write datain=0xDEADBEEF at 0x10, then read 0x10 -> ack 2 cycles after req each time; dataout=0xDEADBEEF; m[0x10]=0xDE, m[0x13]=0xEF.
REQ-030 WAIT_CYCLES=0, read 0x10 -> ack on the cycle after req sampled; busy high one cycle.
REQ-031 Write 0x11223344 at 0xFE -> m[0xFE]=0x11, m[0xFF]=0x22, m[0x00]=0x33, m[0x01]=0x44; read 0xFE returns 0x11223344; read address 0x1000_00FE aliases to the same value.
REQ-032 WAIT_CYCLES=3, write 0xCAFEF00D at 0x20, reset=0 asserted during the 2nd WAIT cycle -> ack never pulses, outputs zero; a later read of 0x20 returns the prior contents.
REQ-033 Macro defined, write 0x55 at 0x21 -> ack=1 and err=1 same cycle; m[0x20..0x23] unchanged. Macro undefined, same stimulus -> err=0; m[0x21..0x24]=00,00,00,55.
REQ-034 req held high across 3 transactions, read, read, write -> acks spaced exactly WAIT_CYCLES+2 cycles; no request accepted while busy=1.

Source files
------------

// File: rtl/mem_responder.sv
// Byte-addressed 32-bit memory responder with a req/ack handshake, programmable wait states and big-endian word access.
// Optional alignment checking is enabled with macro MEM_RESPONDER_ALIGN_CHECK_EN.
module mem_responder #(
  parameter int ADDR_BITS   = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [31:0] address,
  input  logic [31:0] datain,
  output logic [31:0] dataout,
  output logic        ack,
  output logic        err,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                 state_r;
  logic [3:0]             cnt_r;
  logic [ADDR_BITS-1:0]   addr_r;
  logic                   wr_r;
  logic [31:0]            data_r;
  logic [7:0]             mem_r [0:(1 << ADDR_BITS) - 1];

  logic [ADDR_BITS-1:0]   acc_addr_s;
  logic                   acc_wr_s;
  logic [31:0]            acc_data_s;
  logic                   enter_resp_s;
  logic                   misal_s;
  logic [31:0]            rd_word_s;
  logic                   unused_s;

  assign unused_s = ^address[31:ADDR_BITS];

  // Byte lanes beyond the base address wrap within the storage size.
  function automatic logic [ADDR_BITS-1:0] byte_idx(input logic [ADDR_BITS-1:0] base,
                                                    input logic [1:0]           off);
    return base + ADDR_BITS'(off);
  endfunction

  // With zero wait states the access happens on the sampling edge, before the latches are loaded.
  always_comb begin
    if (state_r == IDLE) begin
      acc_addr_s = address[ADDR_BITS-1:0];
      acc_wr_s   = wr;
      acc_data_s = datain;
    end else begin
      acc_addr_s = addr_r;
      acc_wr_s   = wr_r;
      acc_data_s = data_r;
    end
  end

  // Detect the edge on which the FSM moves into RESP.
  always_comb begin
    case (state_r)
      IDLE:    enter_resp_s = req && (WAIT_CYCLES == 0);
      WAIT:    enter_resp_s = (cnt_r <= 4'd1);
      default: enter_resp_s = 1'b0;
    endcase
  end

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
  assign misal_s = (acc_addr_s[1:0] != 2'b00);
`else
  assign misal_s = 1'b0;
`endif

  assign rd_word_s = {mem_r[byte_idx(acc_addr_s, 2'd0)], mem_r[byte_idx(acc_addr_s, 2'd1)],
                      mem_r[byte_idx(acc_addr_s, 2'd2)], mem_r[byte_idx(acc_addr_s, 2'd3)]};

  // Storage is deliberately outside the reset domain so its contents survive reset.
  always_ff @(posedge clk) begin
    if (enter_resp_s && acc_wr_s && !misal_s) begin
      mem_r[byte_idx(acc_addr_s, 2'd0)] <= acc_data_s[31:24];
      mem_r[byte_idx(acc_addr_s, 2'd1)] <= acc_data_s[23:16];
      mem_r[byte_idx(acc_addr_s, 2'd2)] <= acc_data_s[15:8];
      mem_r[byte_idx(acc_addr_s, 2'd3)] <= acc_data_s[7:0];
    end
  end

  // Handshake FSM with registered ack/err/busy/dataout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      addr_r  <= '0;
      wr_r    <= 1'b0;
      data_r  <= 32'd0;
      dataout <= 32'd0;
      ack     <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req) begin
            addr_r  <= address[ADDR_BITS-1:0];
            wr_r    <= wr;
            data_r  <= datain;
            cnt_r   <= 4'(WAIT_CYCLES);
            busy    <= 1'b1;
            state_r <= enter_resp_s ? RESP : WAIT;
          end else begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        WAIT: begin
          cnt_r   <= cnt_r - 4'd1;
          busy    <= 1'b1;
          state_r <= enter_resp_s ? RESP : WAIT;
        end
        RESP: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          cnt_r   <= 4'd0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
      ack <= enter_resp_s;
      err <= enter_resp_s && misal_s;
      if (enter_resp_s && !acc_wr_s && !misal_s) begin
        dataout <= rd_word_s;
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder: three instances with 1, 0 and 3 wait states.
module tb_mem_responder;

  localparam int WC [3] = '{1, 0, 3};
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset   [3];
  logic        req     [3];
  logic        wr      [3];
  logic [31:0] address [3];
  logic [31:0] datain  [3];
  logic [31:0] dataout [3];
  logic        ack     [3];
  logic        err     [3];
  logic        busy    [3];
  logic [31:0] last_rd [3];
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_responder #(.ADDR_BITS(8), .WAIT_CYCLES(1)) u_dut_w1 (
    .clk(clk), .reset(reset[0]), .req(req[0]), .wr(wr[0]), .address(address[0]),
    .datain(datain[0]), .dataout(dataout[0]), .ack(ack[0]), .err(err[0]), .busy(busy[0]));
  mem_responder #(.ADDR_BITS(8), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk(clk), .reset(reset[1]), .req(req[1]), .wr(wr[1]), .address(address[1]),
    .datain(datain[1]), .dataout(dataout[1]), .ack(ack[1]), .err(err[1]), .busy(busy[1]));
  mem_responder #(.ADDR_BITS(8), .WAIT_CYCLES(3)) u_dut_w3 (
    .clk(clk), .reset(reset[2]), .req(req[2]), .wr(wr[2]), .address(address[2]),
    .datain(datain[2]), .dataout(dataout[2]), .ack(ack[2]), .err(err[2]), .busy(busy[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete handshake; the initiator drops req as soon as it sees ack.
  task automatic txn(input int i, input bit w, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] dout, output bit e, output int lat, output int bsy);
    bit got;
    got  = 1'b0;
    dout = 32'd0;
    e    = 1'b0;
    lat  = 0;
    bsy  = 0;
    @(negedge clk);
    req[i] = 1'b1; wr[i] = w; address[i] = a; datain[i] = d;
    for (int n = 1; n <= 40 && !got; n++) begin
      @(posedge clk); #1;
      if (busy[i]) bsy++;
      if (ack[i]) begin
        got  = 1'b1;
        lat  = n;
        e    = err[i];
        dout = dataout[i];
        req[i] = 1'b0;
      end
    end
    req[i] = 1'b0;
    chk($sformatf("ack_seen%0d@%h", i, a), 32'(got), 32'd1);
    @(posedge clk); #1;
    chk($sformatf("ack_pulse%0d@%h", i, a), 32'(ack[i]), 32'd0);
    chk($sformatf("busy_clr%0d@%h", i, a), 32'(busy[i]), 32'd0);
  endtask

  task automatic wr_chk(input int i, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] dout;
    bit e;
    int lat, bsy;
    bit misal;
    misal = ALIGN_EN && (a[1:0] != 2'b00);
    txn(i, 1'b1, a, d, dout, e, lat, bsy);
    chk($sformatf("wr_lat%0d@%h", i, a), 32'(lat), 32'(WC[i] + 1));
    chk($sformatf("wr_err%0d@%h", i, a), 32'(e), 32'(misal));
  endtask

  task automatic rd_chk(input int i, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] dout;
    bit e;
    int lat, bsy;
    bit misal;
    misal = ALIGN_EN && (a[1:0] != 2'b00);
    txn(i, 1'b0, a, 32'd0, dout, e, lat, bsy);
    chk($sformatf("rd_data%0d@%h", i, a), dout, misal ? last_rd[i] : exp);
    chk($sformatf("rd_lat%0d@%h", i, a), 32'(lat), 32'(WC[i] + 1));
    chk($sformatf("rd_busy%0d@%h", i, a), 32'(bsy), 32'(WC[i] + 1));
    chk($sformatf("rd_err%0d@%h", i, a), 32'(e), 32'(misal));
    if (!misal) last_rd[i] = exp;
  endtask

  task automatic wait_ack(input int i, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(posedge clk); #1;
      if (ack[i]) ok = 1'b1;
    end
  endtask

  initial begin
    bit ok, seen;
    int t1, t2, t3;
    for (int i = 0; i < 3; i++) begin
      reset[i] = 1'b0; req[i] = 1'b0; wr[i] = 1'b0;
      address[i] = 32'd0; datain[i] = 32'd0; last_rd[i] = 32'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dataout", dataout[0], 32'd0);
    chk("rst_ack", 32'(ack[0]), 32'd0);
    chk("rst_err", 32'(err[0]), 32'd0);
    chk("rst_busy", 32'(busy[0]), 32'd0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) reset[i] = 1'b1;

    // Basic write/read and big-endian byte order.
    wr_chk(0, 32'h14, 32'h0000_0000);
    wr_chk(0, 32'h10, 32'hDEAD_BEEF);
    rd_chk(0, 32'h10, 32'hDEAD_BEEF);
    rd_chk(0, 32'h13, 32'hEF00_0000);

    // Wrap of byte lanes past the top of storage, and address aliasing.
    wr_chk(0, 32'h00, 32'h0000_0000);
    wr_chk(0, 32'hFC, 32'h0000_0000);
    wr_chk(0, 32'hFE, 32'h1122_3344);
    rd_chk(0, 32'hFE, 32'h1122_3344);
    rd_chk(0, 32'h1000_00FE, 32'h1122_3344);
    rd_chk(0, 32'h00, ALIGN_EN ? 32'h0000_0000 : 32'h3344_0000);
    rd_chk(0, 32'hFC, ALIGN_EN ? 32'h0000_0000 : 32'h0000_1122);

    // Unaligned write: committed or suppressed depending on the alignment option.
    wr_chk(0, 32'h20, 32'hA1A2_A3A4);
    wr_chk(0, 32'h24, 32'hB1B2_B3B4);
    wr_chk(0, 32'h21, 32'h0000_0055);
    rd_chk(0, 32'h20, ALIGN_EN ? 32'hA1A2_A3A4 : 32'hA100_0000);
    rd_chk(0, 32'h24, ALIGN_EN ? 32'hB1B2_B3B4 : 32'h55B2_B3B4);

    // req held high across read, read, write.
    @(negedge clk);
    req[0] = 1'b1; wr[0] = 1'b0; address[0] = 32'h10;
    wait_ack(0, ok);
    t1 = cyc;
    chk("b2b_ack1", 32'(ok), 32'd1);
    chk("b2b_rd1", dataout[0], 32'hDEAD_BEEF);
    address[0] = 32'h24;
    wait_ack(0, ok);
    t2 = cyc;
    chk("b2b_ack2", 32'(ok), 32'd1);
    chk("b2b_rd2", dataout[0], ALIGN_EN ? 32'hB1B2_B3B4 : 32'h55B2_B3B4);
    chk("b2b_gap1", 32'(t2 - t1), 32'(WC[0] + 2));
    wr[0] = 1'b1; address[0] = 32'h30; datain[0] = 32'h0BAD_F00D;
    wait_ack(0, ok);
    t3 = cyc;
    req[0] = 1'b0; wr[0] = 1'b0;
    chk("b2b_ack3", 32'(ok), 32'd1);
    chk("b2b_gap2", 32'(t3 - t2), 32'(WC[0] + 2));
    chk("b2b_wr_keeps_dout", dataout[0], ALIGN_EN ? 32'hB1B2_B3B4 : 32'h55B2_B3B4);
    last_rd[0] = ALIGN_EN ? 32'hB1B2_B3B4 : 32'h55B2_B3B4;
    @(posedge clk); #1;
    chk("b2b_ack_low", 32'(ack[0]), 32'd0);
    rd_chk(0, 32'h30, 32'h0BAD_F00D);

    // Zero wait states.
    wr_chk(1, 32'h10, 32'h1234_5678);
    rd_chk(1, 32'h10, 32'h1234_5678);

    // Three wait states, reset during the second wait cycle aborts a write.
    wr_chk(2, 32'h20, 32'h0102_0304);
    rd_chk(2, 32'h20, 32'h0102_0304);
    @(negedge clk);
    req[2] = 1'b1; wr[2] = 1'b1; address[2] = 32'h20; datain[2] = 32'hCAFE_F00D;
    @(posedge clk);
    @(posedge clk); #1;
    reset[2] = 1'b0; req[2] = 1'b0; wr[2] = 1'b0;
    #1;
    chk("abort_dout", dataout[2], 32'd0);
    chk("abort_ack", 32'(ack[2]), 32'd0);
    chk("abort_busy", 32'(busy[2]), 32'd0);
    chk("abort_err", 32'(err[2]), 32'd0);
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      seen = seen | ack[2];
    end
    chk("abort_no_ack", 32'(seen), 32'd0);
    @(negedge clk);
    reset[2] = 1'b1;
    last_rd[2] = 32'd0;
    rd_chk(2, 32'h20, 32'h0102_0304);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
